// File: rtl/topmod_sched.sv
// Round-robin, credit-limited issue controller sharing one registered datapath
// between two requesters; results return through a small {id,q} FIFO.
module topmod_sched #(
  parameter int RES_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] op0,
  input  logic [3:0] op1,
  output logic [1:0] gnt,
  output logic [3:0] dp_in,
  output logic       dp_rst,
  input  logic       dp_q,
  output logic       res_valid,
  output logic       res_q,
  output logic       res_id,
  input  logic       res_ready
);

  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(RES_DEPTH);

  logic          prio;
  logic          s1_v;
  logic          s1_id;
  logic [1:0]    mem [RES_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          pop;
  logic          push;
  logic [CW:0]   occ;
  logic [CW:0]   avail;
  logic          issue_ok;
  logic          grant;
  logic          sel;

  assign dp_rst    = ~rst;
  assign res_valid = (count != '0);
  assign res_q     = mem[rd_ptr][0];
  assign res_id    = mem[rd_ptr][1];
  assign pop       = res_valid & res_ready;
  assign push      = s1_v;

  // An in-flight operation already owns a FIFO slot, so it counts against credit.
  assign occ      = {1'b0, count} + {{CW{1'b0}}, s1_v};
  assign avail    = occ - {{CW{1'b0}}, pop};
  assign issue_ok = rst & (avail < DEPTH_C);

  always_comb begin
    grant = 1'b0;
    sel   = 1'b0;
    if (issue_ok && req != 2'b00) begin
      grant = 1'b1;
      case (req)
        2'b01:   sel = 1'b0;
        2'b10:   sel = 1'b1;
        default: sel = prio;
      endcase
    end
  end

  always_comb begin
    gnt   = 2'b00;
    dp_in = 4'b0000;
    if (grant) begin
      gnt[sel] = 1'b1;
      dp_in    = sel ? op1 : op0;
    end
  end

  // Storage is cleared on reset so the head reads zero and no stale entry can leak out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio   <= 1'b0;
      s1_v   <= 1'b0;
      s1_id  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RES_DEPTH; i++) mem[i] <= 2'b00;
    end else begin
      if (grant) prio <= ~sel;
      s1_v  <= grant;
      s1_id <= sel;
      if (push) begin
        mem[wr_ptr] <= {s1_id, dp_q};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_topmod_sched.sv
// Randomized bench for topmod_sched: a behavioural datapath feeds dp_q, and a
// queue-based model of arbitration, credit and result order predicts every output.
module tb_topmod_sched;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] op0 = 4'h0;
  logic [3:0] op1 = 4'h0;
  logic [1:0] gnt;
  logic [3:0] dp_in;
  logic       dp_rst;
  logic       dp_q;
  logic       res_valid;
  logic       res_q;
  logic       res_id;
  logic       res_ready = 1'b0;

  int numCompared   = 0;
  int numMismatched = 0;

  // Model state
  bit         known = 0;
  int         prio = 0;
  bit         infV = 0;
  bit         infId = 0;
  logic       infQ = 1'b0;
  logic [1:0] fifoQ[$];
  bit         pending[2];
  logic [3:0] opnd[2];
  logic [3:0] opCounter = 4'h0;

  function automatic logic dpFunc(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] ^ v[0]);
  endfunction

  always #5 clk = ~clk;

  // Stand-in for the shared datapath: one register stage after the logic function.
  logic dpReg;
  always @(posedge clk) dpReg <= dp_rst ? 1'b0 : dpFunc(dp_in);
  assign dp_q = dpReg;

  topmod_sched #(.RES_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op0       (op0),
    .op1       (op1),
    .gnt       (gnt),
    .dp_in     (dp_in),
    .dp_rst    (dp_rst),
    .dp_q      (dp_q),
    .res_valid (res_valid),
    .res_q     (res_q),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    numCompared++;
    if (obs !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: requesters raise/hold requests, outputs are checked against
  // the model mid-cycle, and the model advances at the rising edge.
  task automatic applyStimulus(input int pct0, input int pct1, input int readyPct,
                               input int opMode, input logic rstVal);
    bit         expValid;
    bit         doPop;
    bit         doGrant;
    int         occ;
    int         sel;
    logic [1:0] expGnt;
    logic [3:0] expDin;
    @(negedge clk);
    rst = rstVal;
    for (int i = 0; i < 2; i++) begin
      if (!pending[i] && $urandom_range(99) < ((i == 0) ? pct0 : pct1)) begin
        pending[i] = 1;
        if (opMode == 1 && i == 0) begin
          opnd[i] = opCounter;
          opCounter = opCounter + 4'h1;
        end else begin
          opnd[i] = 4'($urandom);
        end
      end
    end
    req       = {pending[1], pending[0]};
    op0       = opnd[0];
    op1       = opnd[1];
    res_ready = ($urandom_range(99) < readyPct);
    #1;
    expValid = (fifoQ.size() != 0);
    doPop    = rst && expValid && res_ready;
    occ      = fifoQ.size() + int'(infV);
    expGnt   = 2'b00;
    expDin   = 4'h0;
    doGrant  = 0;
    sel      = 0;
    if (rst && req != 2'b00 && (occ - int'(doPop)) < DEPTH) begin
      doGrant = 1;
      sel     = (req == 2'b11) ? prio : (req[1] ? 1 : 0);
      expGnt  = 2'b01 << sel;
      expDin  = opnd[sel];
    end
    checkOutput("gnt", {6'b0, gnt}, {6'b0, expGnt});
    checkOutput("dp_in", {4'b0, dp_in}, {4'b0, expDin});
    checkOutput("dp_rst", {7'b0, dp_rst}, {7'b0, ~rst});
    if (known) begin
      checkOutput("res_valid", {7'b0, res_valid}, {7'b0, expValid});
      if (expValid) begin
        checkOutput("res_id", {7'b0, res_id}, {7'b0, fifoQ[0][1]});
        checkOutput("res_q", {7'b0, res_q}, {7'b0, fifoQ[0][0]});
      end
    end
    @(posedge clk);
    if (!rst) begin
      known = 1;
      prio  = 0;
      infV  = 0;
      fifoQ.delete();
    end else begin
      if (doPop) void'(fifoQ.pop_front());
      if (infV) fifoQ.push_back({infId, infQ});
      infV = doGrant;
      if (doGrant) begin
        infId        = sel[0];
        infQ         = dpFunc(opnd[sel]);
        prio         = 1 - sel;
        pending[sel] = 0;
      end
    end
  endtask

  initial begin
    pending[0] = 0;
    pending[1] = 0;
    opnd[0]    = 4'h0;
    opnd[1]    = 4'h0;

    // Held reset with both requesting: nothing may be granted.
    for (int i = 0; i < 3; i++) applyStimulus(100, 100, 100, 0, 1'b0);

    // Both requesters always active, consumer always ready: strict alternation.
    for (int i = 0; i < 20; i++) applyStimulus(100, 100, 100, 0, 1'b1);

    // Requester 0 alone walking through every operand value.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 100, 0, 1'b1);
    opCounter = 4'h0;
    for (int i = 0; i < 20; i++) applyStimulus(100, 0, 100, 1, 1'b1);

    // Backpressure: fill the FIFO, then single-cycle pops.
    for (int i = 0; i < 6; i++) applyStimulus(100, 100, 0, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(100, 100, 100, 0, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(100, 100, 0, 0, 1'b1);
    end

    // Mixed random traffic and consumer stalls.
    for (int i = 0; i < 200; i++) applyStimulus(60, 60, 50, 0, 1'b1);

    // Reset with one result queued and one in flight.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 100, 0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(100, 100, 0, 0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(100, 100, 50, 0, 1'b0);
    for (int i = 0; i < 60; i++) applyStimulus(70, 70, 60, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
